dcache_req_ctrl: RTL and testbench



---
 rtl/drac_pkg.sv | 48 ++++
 rtl/dcache_req_ctrl.sv | 158 +++++++++++++++
 tb/tb_dcache_req_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/drac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | drac_pkg : shared types and widths for the core-side DMEM requester      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package drac_pkg;

   localparam int ADDR_W = 40;
   localparam int DATA_W = 64;
   localparam int TAG_W  = 8;

   localparam logic [4:0] M_XRD = 5'd0;
   localparam logic [4:0] M_XWR = 5'd1;

   typedef enum logic [2:0] {
      DREQ_IDLE = 3'd0,
      DREQ_REQ  = 3'd1,
      DREQ_S1   = 3'd2,
      DREQ_S2   = 3'd3,
      DREQ_WAIT = 3'd4
   } dreq_state_t;

   typedef enum logic [1:0] {
      XCPT_MA_LD = 2'd0,
      XCPT_MA_ST = 2'd1,
      XCPT_PF_LD = 2'd2,
      XCPT_PF_ST = 2'd3
   } xcpt_cause_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [4:0]        cmd;
      logic [2:0]        typ;
   } req_cpu_dcache_t;

   // Lowest-numbered cause wins when several exception bits arrive together.
   function automatic xcpt_cause_t xcpt_prio(input logic ma_ld, input logic ma_st,
                                             input logic pf_ld, input logic pf_st);
      if (ma_ld)      return XCPT_MA_LD;
      else if (ma_st) return XCPT_MA_ST;
      else if (pf_ld) return XCPT_PF_LD;
      else if (pf_st) return XCPT_PF_ST;
      else            return XCPT_MA_LD;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_req_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_req_ctrl : single-request DMEM requester with nack/kill handling  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module dcache_req_ctrl
   import drac_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   input  logic              req_kill_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_data_i,
   input  logic [4:0]        req_cmd_i,
   input  logic [2:0]        req_typ_i,
   output logic              dmem_req_valid_o,
   output logic [ADDR_W-1:0] dmem_req_addr_o,
   output logic [DATA_W-1:0] dmem_req_data_o,
   output logic [4:0]        dmem_req_cmd_o,
   output logic [2:0]        dmem_req_typ_o,
   output logic [TAG_W-1:0]  dmem_req_tag_o,
   output logic              dmem_s1_kill_o,
   input  logic              dmem_req_ready_i,
   input  logic              dmem_resp_valid_i,
   input  logic              dmem_resp_nack_i,
   input  logic              dmem_resp_replay_i,
   input  logic [TAG_W-1:0]  dmem_resp_tag_i,
   input  logic [DATA_W-1:0] dmem_resp_data_i,
   input  logic              dmem_xcpt_ma_ld_i,
   input  logic              dmem_xcpt_ma_st_i,
   input  logic              dmem_xcpt_pf_ld_i,
   input  logic              dmem_xcpt_pf_st_i,
   input  logic              dmem_ordered_i,
   output logic              lock_o,
   output logic              resp_valid_o,
   output logic [DATA_W-1:0] resp_data_o,
   output logic              xcpt_o,
   output logic [1:0]        xcpt_cause_o
);

   localparam logic [2:0] S_IDLE = DREQ_IDLE;
   localparam logic [2:0] S_REQ  = DREQ_REQ;
   localparam logic [2:0] S_S1   = DREQ_S1;
   localparam logic [2:0] S_S2   = DREQ_S2;
   localparam logic [2:0] S_WAIT = DREQ_WAIT;

   logic [2:0]        state_q, state_d;
   logic [TAG_W-1:0]  tag_q;
   req_cpu_dcache_t   req_q;
   logic              kill_q;
   logic              resp_valid_q;
   logic [DATA_W-1:0] resp_data_q;
   logic              xcpt_q;
   xcpt_cause_t       cause_q;

   logic accept, complete, take_xcpt;
   logic is_load, resp_hit, xcpt_any;

   assign is_load  = (req_q.cmd == M_XRD);
   // Stale responses from abandoned requests are filtered by the tag compare.
   assign resp_hit = (dmem_resp_valid_i | dmem_resp_replay_i) && (dmem_resp_tag_i == tag_q);
   assign xcpt_any = dmem_xcpt_ma_ld_i | dmem_xcpt_ma_st_i | dmem_xcpt_pf_ld_i | dmem_xcpt_pf_st_i;

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      complete  = 1'b0;
      take_xcpt = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i && !req_kill_i) begin
               accept  = 1'b1;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (dmem_req_ready_i)  state_d = S_S1;
            else if (req_kill_i)   state_d = S_IDLE;
         end
         S_S1: begin
            if (req_kill_i || kill_q) state_d = S_IDLE;
            else                      state_d = S_S2;
         end
         S_S2: begin
            if (req_kill_i) begin
               state_d = S_IDLE;
            end else if (xcpt_any) begin
               take_xcpt = 1'b1;
               state_d   = S_IDLE;
            end else if (dmem_resp_nack_i) begin
               state_d = S_REQ;
            end else if (is_load && resp_hit) begin
               complete = 1'b1;
               state_d  = S_IDLE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (req_kill_i) begin
               state_d = S_IDLE;
            end else if (dmem_resp_nack_i) begin
               state_d = S_REQ;
            end else if ((is_load && resp_hit) || (!is_load && dmem_ordered_i)) begin
               complete = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         tag_q        <= '0;
         req_q        <= '0;
         kill_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         xcpt_q       <= 1'b0;
         cause_q      <= XCPT_MA_LD;
      end else begin
         state_q      <= state_d;
         // A kill coinciding with the cache handshake must still reach s1.
         kill_q       <= (state_q == S_REQ) && dmem_req_ready_i && req_kill_i;
         resp_valid_q <= complete;
         xcpt_q       <= take_xcpt;
         if (accept) begin
            tag_q      <= tag_q + 1'b1;
            req_q.addr <= req_addr_i;
            req_q.data <= req_data_i;
            req_q.cmd  <= req_cmd_i;
            req_q.typ  <= req_typ_i;
         end
         if (complete && is_load) resp_data_q <= dmem_resp_data_i;
         if (take_xcpt)
            cause_q <= xcpt_prio(dmem_xcpt_ma_ld_i, dmem_xcpt_ma_st_i,
                                 dmem_xcpt_pf_ld_i, dmem_xcpt_pf_st_i);
      end
   end

   assign dmem_req_valid_o = (state_q == S_REQ);
   assign dmem_req_addr_o  = req_q.addr;
   assign dmem_req_data_o  = req_q.data;
   assign dmem_req_cmd_o   = req_q.cmd;
   assign dmem_req_typ_o   = req_q.typ;
   assign dmem_req_tag_o   = tag_q;
   assign dmem_s1_kill_o   = (state_q == S_S1) && (req_kill_i || kill_q);
   assign lock_o           = (state_q != S_IDLE);
   assign resp_valid_o     = resp_valid_q;
   assign resp_data_o      = resp_data_q;
   assign xcpt_o           = xcpt_q;
   assign xcpt_cause_o     = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_req_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dcache_req_ctrl : directed self-checking bench for dcache_req_ctrl    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_dcache_req_ctrl;
   import drac_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid, req_kill;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic [4:0]        req_cmd;
   logic [2:0]        req_typ;
   logic              dmem_req_valid;
   logic [ADDR_W-1:0] dmem_req_addr;
   logic [DATA_W-1:0] dmem_req_data;
   logic [4:0]        dmem_req_cmd;
   logic [2:0]        dmem_req_typ;
   logic [TAG_W-1:0]  dmem_req_tag;
   logic              dmem_s1_kill;
   logic              ready, resp_v, nack, replay;
   logic [TAG_W-1:0]  resp_tag;
   logic [DATA_W-1:0] resp_dat;
   logic              ma_ld, ma_st, pf_ld, pf_st, ordered;
   logic              lock, resp_valid, xcpt;
   logic [DATA_W-1:0] resp_data;
   logic [1:0]        xcpt_cause;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dcache_req_ctrl dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_kill_i(req_kill), .req_addr_i(req_addr),
      .req_data_i(req_data), .req_cmd_i(req_cmd), .req_typ_i(req_typ),
      .dmem_req_valid_o(dmem_req_valid), .dmem_req_addr_o(dmem_req_addr),
      .dmem_req_data_o(dmem_req_data), .dmem_req_cmd_o(dmem_req_cmd),
      .dmem_req_typ_o(dmem_req_typ), .dmem_req_tag_o(dmem_req_tag),
      .dmem_s1_kill_o(dmem_s1_kill), .dmem_req_ready_i(ready),
      .dmem_resp_valid_i(resp_v), .dmem_resp_nack_i(nack), .dmem_resp_replay_i(replay),
      .dmem_resp_tag_i(resp_tag), .dmem_resp_data_i(resp_dat),
      .dmem_xcpt_ma_ld_i(ma_ld), .dmem_xcpt_ma_st_i(ma_st),
      .dmem_xcpt_pf_ld_i(pf_ld), .dmem_xcpt_pf_st_i(pf_st),
      .dmem_ordered_i(ordered), .lock_o(lock), .resp_valid_o(resp_valid),
      .resp_data_o(resp_data), .xcpt_o(xcpt), .xcpt_cause_o(xcpt_cause)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic quiet;
      req_valid = 0; req_kill = 0; req_addr = '0; req_data = '0; req_cmd = '0; req_typ = '0;
      ready = 0; resp_v = 0; nack = 0; replay = 0; resp_tag = '0; resp_dat = '0;
      ma_ld = 0; ma_st = 0; pf_ld = 0; pf_st = 0; ordered = 0;
   endtask

   // Presents one request in IDLE and advances into REQ.
   task automatic issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [4:0] c, input logic [2:0] t);
      req_valid = 1; req_addr = a; req_data = d; req_cmd = c; req_typ = t;
      tick;
      req_valid = 0; req_addr = '0; req_data = '0; req_cmd = '0; req_typ = '0;
   endtask

   task automatic test_reset;
      quiet; rst = 1; tick; tick; rst = 0;
      checks++; if (lock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b want 0", lock); end
      checks++; if ({dmem_req_valid, dmem_s1_kill, resp_valid, xcpt} !== 4'b0000) begin errors++; $display("FAIL reset_valids: got %b want 0000", {dmem_req_valid, dmem_s1_kill, resp_valid, xcpt}); end
      checks++; if (dmem_req_tag !== 8'd0 || dmem_req_addr !== '0 || resp_data !== '0 || xcpt_cause !== 2'd0) begin errors++; $display("FAIL reset_fields: tag=%h addr=%h data=%h cause=%0d want all 0", dmem_req_tag, dmem_req_addr, resp_data, xcpt_cause); end
   endtask

   // Request sampled at edge E1; pulse visible after E4, three edges later.
   task automatic test_load_basic;
      issue(40'h80, 64'h0, M_XRD, 3'd3);
      checks++; if (dmem_req_valid !== 1'b1 || dmem_req_addr !== 40'h80 || dmem_req_tag !== 8'd1 || dmem_req_typ !== 3'd3) begin errors++; $display("FAIL load_req: valid=%b addr=%h tag=%h typ=%0d want 1/80/01/3", dmem_req_valid, dmem_req_addr, dmem_req_tag, dmem_req_typ); end
      checks++; if (lock !== 1'b1) begin errors++; $display("FAIL load_lock_req: got %b want 1", lock); end
      ready = 1; tick; ready = 0;
      checks++; if (lock !== 1'b1 || dmem_req_valid !== 1'b0 || dmem_s1_kill !== 1'b0) begin errors++; $display("FAIL load_s1: lock=%b valid=%b kill=%b want 1/0/0", lock, dmem_req_valid, dmem_s1_kill); end
      tick;
      resp_v = 1; resp_tag = 8'd1; resp_dat = 64'hDEAD;
      checks++; if (lock !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL load_s2: lock=%b resp_valid=%b want 1/0", lock, resp_valid); end
      tick; resp_v = 0; resp_tag = '0; resp_dat = '0;
      checks++; if (resp_valid !== 1'b1 || resp_data !== 64'hDEAD || lock !== 1'b0) begin errors++; $display("FAIL load_done: resp_valid=%b data=%h lock=%b want 1/dead/0", resp_valid, resp_data, lock); end
      tick;
      checks++; if (resp_valid !== 1'b0 || resp_data !== 64'hDEAD) begin errors++; $display("FAIL load_hold: resp_valid=%b data=%h want 0/dead", resp_valid, resp_data); end
   endtask

   task automatic test_ready_stall;
      issue(40'h1000, 64'h55, M_XRD, 3'd2);
      for (int i = 0; i < 4; i++) begin
         checks++; if (dmem_req_valid !== 1'b1 || dmem_req_addr !== 40'h1000 || dmem_req_data !== 64'h55 || dmem_req_tag !== 8'd2 || dmem_req_cmd !== M_XRD || dmem_req_typ !== 3'd2) begin errors++; $display("FAIL stall_fields[%0d]: valid=%b addr=%h data=%h tag=%h cmd=%0d typ=%0d", i, dmem_req_valid, dmem_req_addr, dmem_req_data, dmem_req_tag, dmem_req_cmd, dmem_req_typ); end
         tick;
      end
      ready = 1; tick; ready = 0; tick; tick;
      resp_v = 1; resp_tag = 8'd7; resp_dat = 64'hBAD;
      tick;
      checks++; if (resp_valid !== 1'b0 || lock !== 1'b1) begin errors++; $display("FAIL stall_wrong_tag: resp_valid=%b lock=%b want 0/1", resp_valid, lock); end
      resp_tag = 8'd2; resp_dat = 64'h1234;
      tick; resp_v = 0;
      checks++; if (resp_valid !== 1'b1 || resp_data !== 64'h1234) begin errors++; $display("FAIL stall_done: resp_valid=%b data=%h want 1/1234", resp_valid, resp_data); end
   endtask

   task automatic test_nack_retry;
      int pulses = 0, issues = 0;
      issue(40'h2000, 64'h0, M_XRD, 3'd3);
      ready = 1;
      for (int c = 0; c < 12; c++) begin
         // Cycle map: REQ,S1,S2(nack),REQ,S1,S2(nack),REQ,S1,S2(resp),IDLE...
         nack   = (c == 2 || c == 5);
         resp_v = (c == 8); resp_tag = 8'd3; resp_dat = 64'h77;
         if (dmem_req_valid) begin
            issues++;
            checks++; if (dmem_req_tag !== 8'd3 || dmem_req_addr !== 40'h2000) begin errors++; $display("FAIL nack_reissue: tag=%h addr=%h want 03/2000", dmem_req_tag, dmem_req_addr); end
         end
         tick;
         if (resp_valid) pulses++;
      end
      quiet;
      checks++; if (issues !== 3) begin errors++; $display("FAIL nack_issues: got %0d want 3", issues); end
      checks++; if (pulses !== 1 || resp_data !== 64'h77) begin errors++; $display("FAIL nack_pulses: got %0d data=%h want 1/77", pulses, resp_data); end
   endtask

   task automatic test_store_ordered;
      issue(40'h200, 64'hCAFEBABE, M_XWR, 3'd3);
      checks++; if (dmem_req_cmd !== M_XWR || dmem_req_data !== 64'hCAFEBABE || dmem_req_tag !== 8'd4) begin errors++; $display("FAIL store_req: cmd=%0d data=%h tag=%h want 1/cafebabe/04", dmem_req_cmd, dmem_req_data, dmem_req_tag); end
      ready = 1; tick; ready = 0; tick; tick;
      for (int i = 0; i < 5; i++) begin
         tick;
         checks++; if (resp_valid !== 1'b0 || lock !== 1'b1) begin errors++; $display("FAIL store_wait[%0d]: resp_valid=%b lock=%b want 0/1", i, resp_valid, lock); end
      end
      ordered = 1; tick; ordered = 0;
      checks++; if (resp_valid !== 1'b1 || lock !== 1'b0 || resp_data !== 64'h77) begin errors++; $display("FAIL store_done: resp_valid=%b lock=%b data=%h want 1/0/77", resp_valid, lock, resp_data); end
   endtask

   task automatic test_xcpt;
      logic [3:0] bits [2] = '{4'b0011, 4'b0110};  // {ma_ld,ma_st,pf_ld,pf_st}
      logic [1:0] want [2] = '{2'd2, 2'd1};
      for (int v = 0; v < 2; v++) begin
         issue(40'h300, 64'h0, M_XRD, 3'd3);
         ready = 1; tick; ready = 0; tick;
         {ma_ld, ma_st, pf_ld, pf_st} = bits[v];
         resp_v = 1; resp_tag = dmem_req_tag; resp_dat = 64'hEE;
         tick; quiet;
         checks++; if (xcpt !== 1'b1 || xcpt_cause !== want[v] || resp_valid !== 1'b0 || lock !== 1'b0) begin errors++; $display("FAIL xcpt[%0d]: xcpt=%b cause=%0d resp_valid=%b lock=%b want 1/%0d/0/0", v, xcpt, xcpt_cause, resp_valid, lock, want[v]); end
         tick;
         checks++; if (xcpt !== 1'b0 || resp_data !== 64'h77) begin errors++; $display("FAIL xcpt_end[%0d]: xcpt=%b data=%h want 0/77", v, xcpt, resp_data); end
      end
   endtask

   task automatic test_kill_s1_stale;
      issue(40'h400, 64'h0, M_XRD, 3'd3);  // tag 7
      ready = 1; tick; ready = 0;
      req_kill = 1; #1;
      checks++; if (dmem_s1_kill !== 1'b1) begin errors++; $display("FAIL s1_kill: got %b want 1", dmem_s1_kill); end
      tick; req_kill = 0;
      checks++; if (lock !== 1'b0 || dmem_s1_kill !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL s1_kill_idle: lock=%b kill=%b resp_valid=%b want 0/0/0", lock, dmem_s1_kill, resp_valid); end
      issue(40'h500, 64'h0, M_XRD, 3'd3);  // tag 8
      ready = 1; tick; ready = 0; tick;
      resp_v = 1; resp_tag = 8'd7; resp_dat = 64'hBAD;
      tick; tick;
      checks++; if (resp_valid !== 1'b0 || lock !== 1'b1) begin errors++; $display("FAIL stale_tag: resp_valid=%b lock=%b want 0/1", resp_valid, lock); end
      resp_tag = 8'd8; resp_dat = 64'h600D;
      tick; quiet;
      checks++; if (resp_valid !== 1'b1 || resp_data !== 64'h600D) begin errors++; $display("FAIL post_kill_load: resp_valid=%b data=%h want 1/600d", resp_valid, resp_data); end
   endtask

   task automatic test_kill_req;
      issue(40'h600, 64'h0, M_XRD, 3'd3);  // tag 9
      req_kill = 1; tick; req_kill = 0;
      checks++; if (lock !== 1'b0 || dmem_req_valid !== 1'b0) begin errors++; $display("FAIL req_kill: lock=%b valid=%b want 0/0", lock, dmem_req_valid); end
      req_valid = 1; req_kill = 1; tick; quiet;
      checks++; if (lock !== 1'b0 || dmem_req_tag !== 8'd9) begin errors++; $display("FAIL idle_kill_blocks: lock=%b tag=%h want 0/09", lock, dmem_req_tag); end
      issue(40'h700, 64'h0, M_XRD, 3'd3);  // tag 10
      ready = 1; req_kill = 1; tick; ready = 0; req_kill = 0; #1;
      checks++; if (dmem_s1_kill !== 1'b1 || dmem_req_tag !== 8'd10) begin errors++; $display("FAIL recorded_kill: kill=%b tag=%h want 1/0a", dmem_s1_kill, dmem_req_tag); end
      tick; tick;
      checks++; if (lock !== 1'b0 || resp_valid !== 1'b0 || xcpt !== 1'b0) begin errors++; $display("FAIL recorded_kill_idle: lock=%b resp_valid=%b xcpt=%b want 0/0/0", lock, resp_valid, xcpt); end
   endtask

   task automatic test_reset_midflight;
      issue(40'h800, 64'h99, M_XWR, 3'd1);
      ready = 1; tick; ready = 0;
      rst = 1; tick; rst = 0;
      checks++; if (lock !== 1'b0 || dmem_req_valid !== 1'b0 || dmem_s1_kill !== 1'b0 || dmem_req_tag !== 8'd0 || dmem_req_addr !== '0 || resp_data !== '0) begin errors++; $display("FAIL mid_reset: lock=%b valid=%b kill=%b tag=%h addr=%h data=%h want all 0", lock, dmem_req_valid, dmem_s1_kill, dmem_req_tag, dmem_req_addr, resp_data); end
   endtask

   initial begin
      quiet; rst = 1;
      test_reset;
      test_load_basic;
      test_ready_stall;
      test_nack_retry;
      test_store_ordered;
      test_xcpt;
      test_kill_s1_stale;
      test_kill_req;
      test_reset_midflight;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
